vsm_core: RTL and testbench

VSM_CORE -- requirements
Module: vsm_core

---
 rtl/vsm_defs.sv | 57 +++++
 rtl/vsm_if.sv | 30 +++
 rtl/vsm_alu.sv | 33 +++
 rtl/vsm_core.sv | 140 ++++++++++++++
 tb/tb_vsm_core.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vsm_defs.sv
// Shared definitions for the VSM core: opcode values, FSM state encoding,
// decoded instruction classes and ALU operation select. Imported by the core,
// the ALU and the testbench so every party agrees on the encodings.
package vsm_defs;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpOut = 4'h3;
  localparam logic [3:0] OpJmp = 4'h4;
  localparam logic [3:0] OpLdb = 4'h5;
  localparam logic [3:0] OpAdb = 4'h6;
  localparam logic [3:0] OpJz  = 4'h7;
  localparam logic [3:0] OpJc  = 4'h8;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDecode  = 2'd1,
    StExecute = 2'd2,
    StHalt    = 2'd3
  } state_e;

  // Instruction class registered in DECODE; all three jumps share ClsJmp and
  // rely on a separately registered taken bit.
  typedef enum logic [2:0] {
    ClsNop = 3'd0,
    ClsLda = 3'd1,
    ClsAdd = 3'd2,
    ClsOut = 3'd3,
    ClsJmp = 3'd4,
    ClsLdb = 3'd5,
    ClsAdb = 3'd6,
    ClsHlt = 3'd7
  } cls_e;

  typedef enum logic {
    AluPass = 1'b0,
    AluAdd  = 1'b1
  } alu_op_e;

  function automatic cls_e decode_cls(logic [3:0] op);
    cls_e cls;
    case (op)
      OpLda:             cls = ClsLda;
      OpAdd:             cls = ClsAdd;
      OpOut:             cls = ClsOut;
      OpJmp, OpJz, OpJc: cls = ClsJmp;
      OpLdb:             cls = ClsLdb;
      OpAdb:             cls = ClsAdb;
      OpHlt:             cls = ClsHlt;
      default:           cls = ClsNop;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/vsm_if.sv
// Bus interface of the VSM core.
//   run       : host -> core, enables instruction fetch
//   rom_addr  : core -> ROM, program counter
//   rom_data  : ROM -> core, combinational instruction byte
//   out_data  : core -> host, last value written by OUT
//   out_valid : core -> host, one-cycle pulse on out_data update
//   acc       : core -> host, accumulator (debug)
//   halted    : core -> host, core is in HALT
// master = core side, slave = host/ROM side.
interface vsm_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic [7:0]        acc;
  logic              halted;

  modport master (
    input  run, rom_data,
    output rom_addr, out_data, out_valid, acc, halted
  );

  modport slave (
    output run, rom_data,
    input  rom_addr, out_data, out_valid, acc, halted
  );
endinterface

// File: rtl/vsm_alu.sv
// Combinational ALU of the VSM core.
//   op_i     : AluPass (result = b_i, carry 0) or AluAdd (result = a_i + b_i)
//   a_i, b_i : operands (b_i is B or the zero-extended immediate)
//   result_o : 8-bit result, modulo 256
//   carry_o  : carry out of the addition, 0 for pass
//   zero_o   : result_o == 0
module vsm_alu
  import vsm_defs::*;
(
  input  alu_op_e    op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);
  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    unique case (op_i)
      AluAdd: begin
        result_o = sum[7:0];
        carry_o  = sum[8];
      end
      default: begin
        result_o = b_i;
        carry_o  = 1'b0;
      end
    endcase
    zero_o = (result_o == 8'h00);
  end
endmodule

// File: rtl/vsm_core.sv
// Very small microprocessor core: 8-bit accumulator machine executing one
// instruction every three cycles (FETCH, DECODE, EXECUTE) from a combinational
// instruction ROM.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : vsm_if master modport (run, ROM port, OUT port, debug acc, halted)
module vsm_core
  import vsm_defs::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input logic   clk,
  input logic   reset_n,
  vsm_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  cls_e              cls_q, cls_d;
  logic              taken_q, taken_d;

  alu_op_e           alu_op;
  logic [7:0]        alu_b;
  logic [7:0]        alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic [ADDR_W-1:0] jump_target;

  assign jump_target = ADDR_W'(ir_q[3:0]);
  assign alu_op      = (cls_q == ClsLda) ? AluPass : AluAdd;
  assign alu_b       = (cls_q == ClsAdb) ? b_q : {4'h0, ir_q[3:0]};

  vsm_alu u_alu (
    .op_i    (alu_op),
    .a_i     (a_q),
    .b_i     (alu_b),
    .result_o(alu_result),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      ir_q        <= 8'h00;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      cls_q       <= ClsNop;
      taken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cls_q       <= cls_d;
      taken_q     <= taken_d;
    end
  end

  // Next-state logic. run only gates the FETCH->DECODE step, so an
  // instruction already past FETCH always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (bus.run) state_d = StDecode;
      StDecode:  state_d = StExecute;
      StExecute: state_d = (cls_q == ClsHlt) ? StHalt : StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  // Datapath updates per state.
  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    cls_d       = cls_q;
    taken_d     = taken_q;
    unique case (state_q)
      StFetch: begin
        if (bus.run) begin
          ir_d = bus.rom_data;
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      StDecode: begin
        cls_d   = decode_cls(ir_q[7:4]);
        taken_d = (ir_q[7:4] == OpJmp) ||
                  ((ir_q[7:4] == OpJz) && z_q) ||
                  ((ir_q[7:4] == OpJc) && c_q);
      end
      StExecute: begin
        unique case (cls_q)
          ClsLda, ClsAdd, ClsAdb: begin
            a_d = alu_result;
            z_d = alu_zero;
            c_d = alu_carry;
          end
          ClsLdb: b_d = {4'h0, ir_q[3:0]};
          ClsOut: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
          end
          // Overrides the PC already incremented in FETCH.
          ClsJmp: if (taken_q) pc_d = jump_target;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.rom_addr  = pc_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = a_q;
  assign bus.halted    = (state_q == StHalt);
endmodule

// File: tb/tb_vsm_core.sv
// Testbench for vsm_core: an instruction-level reference model predicts OUT
// values into a scoreboard queue; a monitor pops and compares on out_valid.
module tb_vsm_core;
  import vsm_defs::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vsm_if #(.ADDR_W(4)) bus ();

  vsm_core #(.ADDR_W(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [7:0] rom [16];
  always_comb bus.rom_data = rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  // Reference model state (architectural, instruction granularity).
  int m_pc, m_a, m_b, m_out;
  bit m_z, m_c, m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0;
    m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic model_exec(input int n);
    for (int i = 0; i < n && !m_halt; i++) begin
      int op, imm, s;
      op   = int'(rom[m_pc]) / 16;
      imm  = int'(rom[m_pc]) % 16;
      m_pc = (m_pc + 1) % 16;
      case (op)
        1: begin m_a = imm; m_c = 0; m_z = (m_a == 0); end
        2: begin s = m_a + imm; m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); end
        3: begin m_out = m_a; exp_q.push_back(8'(m_a)); end
        4: m_pc = imm;
        5: m_b = imm;
        6: begin s = m_a + m_b; m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); end
        7: if (m_z) m_pc = imm;
        8: if (m_c) m_pc = imm;
        15: m_halt = 1;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("out_data", {24'h0, bus.out_data}, {24'h0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, verify reset state, release just before a rising edge.
  task automatic start();
    bus.run = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    #1;
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_acc", bus.acc, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_halted", bus.halted, 0);
    reset_n = 1'b1;
  endtask

  task automatic finish_run();
    bus.run = 1'b0;
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("end_acc", bus.acc, m_a);
    check("end_halted", bus.halted, m_halt);
    check("end_rom_addr", bus.rom_addr, m_pc);
    check("end_out_data", bus.out_data, m_out);
  endtask

  task automatic run_prog(input int k);
    start();
    bus.run = 1'b1;
    model_exec(k);
    tick(3 * k);
    finish_run();
  endtask

  initial begin
    bus.run = 1'b0;

    // Sample program: OUT 0x02, OUT 0x0A, loop from 0.
    rom = '{0: 8'h55, 1: 8'h12, 2: 8'h30, 3: 8'h28, 4: 8'h30, 5: 8'h40, default: 8'h00};
    run_prog(12);

    // Back-to-back ADD F: F, 1E, 2D.
    rom = '{0: 8'h1F, 1: 8'h30, 2: 8'h2F, 3: 8'h30, 4: 8'h2F, 5: 8'h30, 6: 8'hF0,
            default: 8'h00};
    run_prog(10);

    // Repeated ADD F until carry, JC exits the loop: final A = 270 mod 256.
    rom = '{0: 8'h1F, 1: 8'h30, 2: 8'h2F, 3: 8'h85, 4: 8'h41, 5: 8'h30, 6: 8'hF0,
            default: 8'h00};
    run_prog(90);
    check("carry_wrap_acc", bus.acc, 8'h0E);
    check("carry_wrap_halted", bus.halted, 1);

    // JZ taken skips OUT; with LDA 1 it falls through.
    rom = '{0: 8'h10, 1: 8'h73, 2: 8'h30, 3: 8'hF0, default: 8'h00};
    run_prog(6);
    check("jz_taken_halted", bus.halted, 1);
    check("jz_taken_pc", bus.rom_addr, 4);
    rom = '{0: 8'h11, 1: 8'h73, 2: 8'h30, 3: 8'hF0, default: 8'h00};
    run_prog(6);

    // NOPs then HLT at 15: halted on edge 48, then frozen.
    rom = '{15: 8'hF0, default: 8'h00};
    start();
    bus.run = 1'b1;
    model_exec(16);
    tick(45);
    check("halt_pc15", bus.rom_addr, 15);
    tick(2);
    check("halt_not_yet", bus.halted, 0);
    tick(1);
    check("halt_cycle48", bus.halted, 1);
    check("halt_pc_wrap", bus.rom_addr, 0);
    for (int i = 0; i < 10; i++) begin
      bus.run = 1'(i % 2);
      tick(1);
    end
    check("halt_frozen_pc", bus.rom_addr, 0);
    check("halt_frozen_acc", bus.acc, 0);
    check("halt_stays", bus.halted, 1);
    finish_run();

    // Drop run during DECODE: instruction completes, then the core holds.
    rom = '{0: 8'h11, 1: 8'h22, 2: 8'h30, 3: 8'h40, default: 8'h00};
    start();
    bus.run = 1'b1;
    model_exec(10);
    tick(1);
    bus.run = 1'b0;
    tick(2);
    check("stall_acc", bus.acc, 1);
    check("stall_pc", bus.rom_addr, 1);
    tick(5);
    check("stall_pc_hold", bus.rom_addr, 1);
    check("stall_out_quiet", exp_q.size(), 2);
    bus.run = 1'b1;
    tick(27);
    finish_run();

    // Reset during EXECUTE of ADD.
    rom = '{0: 8'h15, 1: 8'h23, 2: 8'h30, 3: 8'hF0, default: 8'h00};
    start();
    bus.run = 1'b1;
    tick(5);
    check("pre_reset_acc", bus.acc, 5);
    reset_n = 1'b0;
    #1;
    check("midrst_acc", bus.acc, 0);
    check("midrst_pc", bus.rom_addr, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    run_prog(4);
    check("restart_acc", bus.acc, 8);

    // Random programs against the model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      run_prog(int'($urandom_range(4, 40)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
